// File: rtl/matrix_scan_ctrl_if.sv
// Framebuffer read port between the scan controller (master) and the pixel RAM (slave).
// The controller presents a row/column/plane address with rd_en and waits for valid.
interface matrix_scan_ctrl_if #(
  parameter int ROWS   = 16,
  parameter int COLS   = 64,
  parameter int PLANES = 4
);
  localparam int RW = (ROWS   > 1) ? $clog2(ROWS)   : 1;
  localparam int CW = (COLS   > 1) ? $clog2(COLS)   : 1;
  localparam int PW = (PLANES > 1) ? $clog2(PLANES) : 1;

  logic          rd_en;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic [PW-1:0] plane;
  logic          valid;
  logic [5:0]    rgb;    // {r1,r0,g1,g0,b1,b0}; index 1 = lower half-panel

  modport master (output rd_en, row, col, plane, input  valid, rgb);
  modport slave  (input  rd_en, row, col, plane, output valid, rgb);
endinterface

// File: rtl/matrix_scan_ctrl.sv
// Scan sequencer for a HUB75-style RGB LED matrix with binary-coded-modulation planes.
// Per plane: fetch and shift COLS pixel pairs, latch the row, hold OE for BASE_OE<<plane
// cycles, blank for BLANK cycles, then advance plane/row. Every output is a register.
module matrix_scan_ctrl #(
  parameter int COLS    = 64,
  parameter int ROWS    = 16,
  parameter int PLANES  = 4,
  parameter int BASE_OE = 8,
  parameter int BLANK   = 2,
  localparam int RW = (ROWS   > 1) ? $clog2(ROWS)   : 1,
  localparam int CW = (COLS   > 1) ? $clog2(COLS)   : 1,
  localparam int PW = (PLANES > 1) ? $clog2(PLANES) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_enable,
  matrix_scan_ctrl_if.master        fb,
  output logic [1:0]                o_mat_r,
  output logic [1:0]                o_mat_g,
  output logic [1:0]                o_mat_b,
  output logic                      o_mat_clk,
  output logic                      o_mat_lat,
  output logic                      o_mat_oe,
  output logic [RW-1:0]             o_mat_row,
  output logic                      o_frame_done,
  output logic                      o_busy
);

  // Display counter must reach the longest on-time (last plane) and the blank period.
  localparam int MAX_ON  = BASE_OE << (PLANES - 1);
  localparam int CNT_MAX = (MAX_ON > BLANK) ? MAX_ON : BLANK;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CW-1:0] COL_LAST   = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);
  localparam logic [PW-1:0] PLANE_LAST = PW'(PLANES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_SHIFT_LO,
    S_SHIFT_HI,
    S_LATCH,
    S_DISPLAY,
    S_BLANK
  } state_t;

  state_t           r_state;
  logic [RW-1:0]    r_row;
  logic [CW-1:0]    r_col;
  logic [PW-1:0]    r_plane;
  logic [CNT_W-1:0] r_cnt;
  logic             r_rd_en;
  logic [1:0]       r_mat_r;
  logic [1:0]       r_mat_g;
  logic [1:0]       r_mat_b;
  logic             r_mat_clk;
  logic             r_mat_lat;
  logic             r_mat_oe;
  logic [RW-1:0]    r_mat_row;
  logic             r_frame_done;
  logic             r_busy;

  // Scan FSM: sequences fetch/shift/latch/display/blank and owns every output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_row        <= '0;
      r_col        <= '0;
      r_plane      <= '0;
      r_cnt        <= '0;
      r_rd_en      <= 1'b0;
      r_mat_r      <= '0;
      r_mat_g      <= '0;
      r_mat_b      <= '0;
      r_mat_clk    <= 1'b0;
      r_mat_lat    <= 1'b0;
      r_mat_oe     <= 1'b1;
      r_mat_row    <= '0;
      r_frame_done <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every branch below see the pre-edge values,
      // so the default pulse-clear here is safely overridden by a later assignment.
      r_frame_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (i_enable) begin
            r_col   <= '0;
            r_rd_en <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= S_FETCH;
          end
        end
        S_FETCH: begin
          // Address stays parked until the RAM answers; the shift clock stays low meanwhile.
          if (fb.valid) begin
            {r_mat_r, r_mat_g, r_mat_b} <= fb.rgb;
            r_rd_en <= 1'b0;
            r_state <= S_SHIFT_LO;
          end
        end
        S_SHIFT_LO: begin
          r_mat_clk <= 1'b1;
          r_state   <= S_SHIFT_HI;
        end
        S_SHIFT_HI: begin
          r_mat_clk <= 1'b0;
          if (r_col == COL_LAST) begin
            r_col     <= '0;
            r_mat_lat <= 1'b1;
            r_mat_row <= r_row;   // row address only moves while OE is inactive
            r_state   <= S_LATCH;
          end else begin
            r_col   <= r_col + 1'b1;
            r_rd_en <= 1'b1;
            r_state <= S_FETCH;
          end
        end
        S_LATCH: begin
          r_mat_lat <= 1'b0;
          r_mat_oe  <= 1'b0;
          r_cnt     <= CNT_W'((BASE_OE << r_plane) - 1);
          r_state   <= S_DISPLAY;
        end
        S_DISPLAY: begin
          if (r_cnt == '0) begin
            r_mat_oe <= 1'b1;
            r_cnt    <= CNT_W'(BLANK - 1);
            r_state  <= S_BLANK;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_BLANK: begin
          if (r_cnt == '0) begin
            if (r_plane == PLANE_LAST) begin
              r_plane <= '0;
              if (r_row == ROW_LAST) begin
                r_row        <= '0;
                r_frame_done <= 1'b1;
              end else begin
                r_row <= r_row + 1'b1;
              end
            end else begin
              r_plane <= r_plane + 1'b1;
            end
            // enable is only honoured at plane boundaries so a plane is never cut short.
            if (i_enable) begin
              r_rd_en <= 1'b1;
              r_state <= S_FETCH;
            end else begin
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign fb.rd_en     = r_rd_en;
  assign fb.row       = r_row;
  assign fb.col       = r_col;
  assign fb.plane     = r_plane;
  assign o_mat_r      = r_mat_r;
  assign o_mat_g      = r_mat_g;
  assign o_mat_b      = r_mat_b;
  assign o_mat_clk    = r_mat_clk;
  assign o_mat_lat    = r_mat_lat;
  assign o_mat_oe     = r_mat_oe;
  assign o_mat_row    = r_mat_row;
  assign o_frame_done = r_frame_done;
  assign o_busy       = r_busy;

endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// Directed bench for matrix_scan_ctrl (COLS=4, ROWS=2, PLANES=2, BASE_OE=4, BLANK=2).
// A 1-cycle-latency RAM returns base+col for each fetch; each plane period is monitored
// against a record of expected row, on-time, blank length and frame_done.
module tb_matrix_scan_ctrl;

  localparam int COLS    = 4;
  localparam int ROWS    = 2;
  localparam int PLANES  = 2;
  localparam int BASE_OE = 4;
  localparam int BLANK   = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_enable = 1'b0;
  logic [1:0] o_mat_r, o_mat_g, o_mat_b;
  logic       o_mat_clk, o_mat_lat, o_mat_oe;
  logic [0:0] o_mat_row;
  logic       o_frame_done, o_busy;

  logic       ram_valid = 1'b0;
  logic [5:0] ram_rgb   = '0;
  logic       ram_hold  = 1'b0;
  logic [5:0] tb_base   = '0;

  int n_checks = 0;
  int n_fail   = 0;

  matrix_scan_ctrl_if #(.ROWS(ROWS), .COLS(COLS), .PLANES(PLANES)) fb ();

  matrix_scan_ctrl #(
    .COLS(COLS), .ROWS(ROWS), .PLANES(PLANES), .BASE_OE(BASE_OE), .BLANK(BLANK)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_enable     (i_enable),
    .fb           (fb),
    .o_mat_r      (o_mat_r),
    .o_mat_g      (o_mat_g),
    .o_mat_b      (o_mat_b),
    .o_mat_clk    (o_mat_clk),
    .o_mat_lat    (o_mat_lat),
    .o_mat_oe     (o_mat_oe),
    .o_mat_row    (o_mat_row),
    .o_frame_done (o_frame_done),
    .o_busy       (o_busy)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] pix(input logic [5:0] base, input int col);
    return base + 6'(col);
  endfunction

  // Pixel RAM model: answers a read the cycle after it sees rd_en, unless stalled.
  assign fb.valid = ram_valid;
  assign fb.rgb   = ram_rgb;
  always @(posedge clk) begin
    if (rst) begin
      ram_valid <= 1'b0;
    end else begin
      ram_valid <= fb.rd_en && !ram_valid && !ram_hold;
      ram_rgb   <= pix(tb_base, int'(fb.col));
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [5:0] base;       // pixel data = base + column
    int         start_col;  // first column whose shift is observed by this record
    bit         drop_en;    // deassert enable early in the display period
    int         exp_row;
    int         exp_on;
    bit         exp_done;
  } vec_t;

  // Observe one plane period from the current point up to the cycle after BLANK.
  task automatic run_plane(input vec_t v);
    int   rises = 0, lat_cnt = 0, oe_low = 0, blank = 0, done_cnt = 0, viol = 0, phase = 0;
    logic lat_row = 1'b0;
    logic prev_clk;
    bit   finished = 0;
    tb_base  = v.base;
    prev_clk = o_mat_clk;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      if (o_mat_clk && !prev_clk) begin
        if (v.start_col + rises < COLS)
          check("shift_data", {o_mat_r, o_mat_g, o_mat_b}, pix(v.base, v.start_col + rises));
        rises++;
      end
      prev_clk = o_mat_clk;
      if (o_mat_lat) begin
        lat_cnt++;
        lat_row = o_mat_row;
        if (o_mat_clk || !o_mat_oe) viol++;
      end
      if (phase != 0 && (o_mat_clk || o_mat_lat)) viol++;
      if (phase == 1 && o_mat_row != lat_row) viol++;
      done_cnt += int'(o_frame_done);
      if (phase == 0 && !o_mat_oe) phase = 1;
      if (phase == 1 && o_mat_oe)  phase = 2;
      if (phase == 1) begin
        oe_low++;
        if (v.drop_en && oe_low == 2) i_enable = 1'b0;
      end else if (phase == 2) begin
        if (fb.rd_en || !o_busy) begin
          finished = 1;
          break;
        end
        blank++;
      end
    end
    check("plane_end",   finished, 1);
    check("clk_rises",   rises,    COLS - v.start_col);
    check("lat_pulses",  lat_cnt,  1);
    check("lat_row",     lat_row,  v.exp_row);
    check("oe_low_len",  oe_low,   v.exp_on);
    check("blank_len",   blank,    BLANK);
    check("frame_done",  done_cnt, v.exp_done ? 1 : 0);
    check("pin_rules",   viol,     0);
  endtask

  vec_t vecs[5];
  vec_t hv;
  bit   found;

  initial begin
    // Full frame plus the first plane of the next frame, enable held high.
    vecs[0] = '{base: 6'h00, start_col: 0, drop_en: 0, exp_row: 0, exp_on: 4, exp_done: 0};
    vecs[1] = '{base: 6'h15, start_col: 0, drop_en: 0, exp_row: 0, exp_on: 8, exp_done: 0};
    vecs[2] = '{base: 6'h2A, start_col: 0, drop_en: 0, exp_row: 1, exp_on: 4, exp_done: 0};
    vecs[3] = '{base: 6'h3E, start_col: 0, drop_en: 0, exp_row: 1, exp_on: 8, exp_done: 1};
    vecs[4] = '{base: 6'h07, start_col: 0, drop_en: 0, exp_row: 0, exp_on: 4, exp_done: 0};

    // Reset values, then idle with enable low.
    repeat (3) @(negedge clk);
    check("rst_oe", o_mat_oe, 1);
    check("rst_others", {fb.rd_en, fb.row, fb.col, fb.plane, o_mat_r, o_mat_g, o_mat_b,
                         o_mat_clk, o_mat_lat, o_mat_row, o_frame_done, o_busy}, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_busy", {o_busy, fb.rd_en, o_mat_oe}, 3'b001);

    i_enable = 1'b1;
    for (int i = 0; i < 5; i++) run_plane(vecs[i]);

    // Enable dropped during plane 1 display: finish the plane, park in IDLE, resume at row 1.
    hv = '{base: 6'h11, start_col: 0, drop_en: 1, exp_row: 0, exp_on: 8, exp_done: 0};
    run_plane(hv);
    repeat (3) begin
      @(negedge clk);
      check("parked_idle", {o_busy, fb.rd_en, o_mat_oe}, 3'b001);
    end
    check("parked_pos", {fb.row, fb.plane, fb.col}, {1'b1, 1'b0, 2'd0});
    i_enable = 1'b1;
    hv = '{base: 6'h20, start_col: 0, drop_en: 0, exp_row: 1, exp_on: 4, exp_done: 0};
    run_plane(hv);

    // Reset while column 1 of row 1 plane 1 is in SHIFT_HI.
    found = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (o_mat_clk && fb.col == 2'd1) begin
        found = 1;
        break;
      end
    end
    check("rst_wait", found, 1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_oe", o_mat_oe, 1);
    check("midrst_others", {fb.rd_en, fb.row, fb.col, fb.plane, o_mat_r, o_mat_g, o_mat_b,
                            o_mat_clk, o_mat_lat, o_mat_row, o_frame_done, o_busy}, 0);
    rst = 1'b0;
    @(negedge clk);
    check("restart_pos", {fb.rd_en, fb.row, fb.plane, fb.col}, {1'b1, 1'b0, 1'b0, 2'd0});
    hv = '{base: 6'h30, start_col: 0, drop_en: 0, exp_row: 0, exp_on: 4, exp_done: 0};
    run_plane(hv);

    // RAM stall at column 2 of row 0 plane 1: address held, no shift clock, no latch.
    tb_base = 6'h09;
    found = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (fb.rd_en && fb.col == 2'd2) begin
        found = 1;
        break;
      end
    end
    check("stall_wait", found, 1);
    ram_hold = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("stall_hold", {fb.rd_en, fb.col, fb.plane, fb.row, o_mat_clk, o_mat_lat},
            {1'b1, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0});
    end
    ram_hold = 1'b0;
    hv = '{base: 6'h09, start_col: 2, drop_en: 0, exp_row: 0, exp_on: 8, exp_done: 0};
    run_plane(hv);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
